// File: rtl/counter_sweep_pkg.sv
// Shared types for the counter sweep sequencer: counter width, FSM states,
// latched command record and the command legality check.
package counter_sweep_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } sweep_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] lo;
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] sweeps;
  } sweep_cmd_t;

  // A legal window keeps the counter strictly inside 0..15, so it never wraps.
  function automatic logic sweep_cmd_valid(input sweep_cmd_t cmd);
    return (cmd.lo < cmd.hi) && (cmd.start >= cmd.lo) && (cmd.start <= cmd.hi);
  endfunction

endpackage

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the 4-bit up/down counter: loads a start value, then
// bounces the count between lo and hi for a programmed number of sweeps.
//
// state | meaning
// IDLE  | ready for a command; counter held by reloading its own value
// LOAD  | counter loaded with the start value
// UP    | counting up until count == hi
// DOWN  | counting down until count == lo, then next sweep or finish
// DONE  | one-cycle done pulse with err/aborted status; count held
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_start,
  input  logic [CNT_W-1:0] cmd_lo,
  input  logic [CNT_W-1:0] cmd_hi,
  input  logic [CNT_W-1:0] cmd_sweeps,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_count,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_up_down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted
);

  sweep_state_t     state_q, state_d;
  sweep_cmd_t       cmd_q, cmd_d;
  sweep_cmd_t       cmd_in;
  logic [CNT_W-1:0] sweeps_left_q, sweeps_left_d;
  logic [CNT_W-1:0] sweeps_dec;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;

  assign cmd_in     = '{start: cmd_start, lo: cmd_lo, hi: cmd_hi, sweeps: cmd_sweeps};
  assign sweeps_dec = sweeps_left_q - 4'd1;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    sweeps_left_d = sweeps_left_q;
    err_d         = err_q;
    aborted_d     = aborted_q;
    cnt_load      = 1'b1;
    cnt_data      = cnt_count;
    cnt_up_down   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d         = cmd_in;
          sweeps_left_d = cmd_sweeps;
          err_d         = 1'b0;
          aborted_d     = 1'b0;
          if (sweep_cmd_valid(cmd_in)) begin
            state_d = ST_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_data = cmd_q.start;
          state_d  = (cmd_q.sweeps == 4'd0) ? ST_DONE : ST_UP;
        end
      end
      ST_UP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_load = 1'b0;
          // Reverse in the same cycle hi is seen so the turn costs no step.
          if (cnt_count == cmd_q.hi) begin
            cnt_up_down = 1'b0;
            state_d     = ST_DOWN;
          end
        end
      end
      ST_DOWN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_load    = 1'b0;
          cnt_up_down = 1'b0;
          if (cnt_count == cmd_q.lo) begin
            sweeps_left_d = sweeps_dec;
            if (sweeps_dec == 4'd0) begin
              cnt_load = 1'b1;
              cnt_data = cmd_q.lo;
              state_d  = ST_DONE;
            end else begin
              cnt_up_down = 1'b1;
              state_d     = ST_UP;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      sweeps_left_q <= '0;
      err_q         <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      sweeps_left_q <= sweeps_left_d;
      err_q         <= err_d;
      aborted_q     <= aborted_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_UP) || (state_q == ST_DOWN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural 4-bit counter closes the loop,
// expected done status/latency/final count are queued per command.
module tb_counter_sweep_ctrl;
  import counter_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_start = '0, cmd_lo = '0, cmd_hi = '0, cmd_sweeps = '0;
  logic       abort = 1'b0;
  logic [3:0] cnt_count = 4'd7;
  logic       cnt_load, cnt_up_down;
  logic [3:0] cnt_data;
  logic       busy, done, err, aborted;

  always #5 clk = ~clk;

  counter_sweep_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_sweeps(cmd_sweeps),
    .abort(abort), .cnt_count(cnt_count), .cnt_load(cnt_load), .cnt_data(cnt_data),
    .cnt_up_down(cnt_up_down), .busy(busy), .done(done), .err(err), .aborted(aborted)
  );

  // Counter model: load has priority, no enable, own reset not used.
  always @(posedge clk) begin
    if (cnt_load)         cnt_count <= cnt_data;
    else if (cnt_up_down) cnt_count <= cnt_count + 4'd1;
    else                  cnt_count <= cnt_count - 4'd1;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic       err;
    logic       aborted;
    logic [3:0] final_cnt;
    int         lat;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] s, l, h, w;
    logic       xerr;
    logic [3:0] xfinal;
    int         xlat;
    string      name;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   accept_edge = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Latency counts the LOAD cycle as T+1, matching done at T+1 for a bad command.
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_err"}, int'(err), int'(mon_e.err));
        chk({mon_e.name, "_aborted"}, int'(aborted), int'(mon_e.aborted));
        chk({mon_e.name, "_count"}, int'(cnt_count), int'(mon_e.final_cnt));
        chk({mon_e.name, "_latency"}, edge_cnt - accept_edge + 1, mon_e.lat);
      end
    end
  end

  task automatic issue(input logic [3:0] s, input logic [3:0] l, input logic [3:0] h,
                       input logic [3:0] w, input logic xerr, input logic xab,
                       input logic [3:0] xfinal, input int xlat, input string name);
    exp_t e;
    @(negedge clk);
    chk({name, "_ready"}, int'(cmd_ready), 1);
    cmd_start = s; cmd_lo = l; cmd_hi = h; cmd_sweeps = w;
    cmd_valid = 1'b1;
    e.err = xerr; e.aborted = xab; e.lat = xlat; e.name = name;
    e.final_cnt = xerr ? cnt_count : xfinal;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    accept_edge = edge_cnt;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[10];
    logic [3:0] trace[6];
    int         dc0;
    int         found;

    vecs[0] = '{4'd3,  4'd2,  4'd5,  4'd1, 1'b0, 4'd2,  8,  "basic"};
    vecs[1] = '{4'd5,  4'd2,  4'd5,  4'd2, 1'b0, 4'd2,  12, "start_hi"};
    vecs[2] = '{4'd6,  4'd6,  4'd6,  4'd3, 1'b1, 4'd0,  1,  "lo_eq_hi"};
    vecs[3] = '{4'd9,  4'd0,  4'd15, 4'd0, 1'b0, 4'd9,  2,  "zero_sweeps"};
    vecs[4] = '{4'd2,  4'd2,  4'd3,  4'd3, 1'b0, 4'd2,  9,  "narrow"};
    vecs[5] = '{4'd0,  4'd0,  4'd15, 4'd1, 1'b0, 4'd0,  33, "full_range"};
    vecs[6] = '{4'd1,  4'd2,  4'd5,  4'd1, 1'b1, 4'd0,  1,  "start_lt_lo"};
    vecs[7] = '{4'd6,  4'd2,  4'd5,  4'd1, 1'b1, 4'd0,  1,  "start_gt_hi"};
    vecs[8] = '{4'd3,  4'd5,  4'd2,  4'd1, 1'b1, 4'd0,  1,  "lo_gt_hi"};
    vecs[9] = '{4'd15, 4'd14, 4'd15, 4'd1, 1'b0, 4'd14, 4,  "top_edge"};

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_cnt_load", int'(cnt_load), 1);
    chk("rst_cnt_up_down", int'(cnt_up_down), 1);
    chk("rst_cnt_data", int'(cnt_data), 7);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].s, vecs[i].l, vecs[i].h, vecs[i].w, vecs[i].xerr, 1'b0,
            vecs[i].xfinal, vecs[i].xlat, vecs[i].name);
      drain(vecs[i].name);
    end

    // Cycle-by-cycle count trace of the basic sweep.
    trace = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    issue(4'd3, 4'd2, 4'd5, 4'd1, 1'b0, 1'b0, 4'd2, 8, "trace");
    @(negedge clk);
    chk("trace_load_strobe", int'(cnt_load), 1);
    chk("trace_load_data", int'(cnt_data), 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("trace_count%0d", i), int'(cnt_count), int'(trace[i]));
    end
    drain("trace");

    // Abort at count 4 while UP, with a competing command offered while busy.
    dc0 = done_cnt;
    issue(4'd2, 4'd2, 4'd6, 4'd1, 1'b0, 1'b1, 4'd4, 5, "abort");
    @(negedge clk);
    cmd_start = 4'd1; cmd_lo = 4'd1; cmd_hi = 4'd1; cmd_sweeps = 4'd0;
    cmd_valid = 1'b1;
    chk("busy_ready", int'(cmd_ready), 0);
    chk("busy_busy", int'(busy), 1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (busy && !cnt_load && cnt_count == 4'd4) found = 1;
    end
    chk("abort_reach4", found, 1);
    abort = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b0;
    drain("abort");
    repeat (3) @(negedge clk);
    chk("abort_hold", int'(cnt_count), 4);
    chk("abort_single_done", done_cnt - dc0, 1);

    // Reset during DOWN, then a normal command.
    issue(4'd2, 4'd2, 4'd6, 4'd1, 1'b0, 1'b0, 4'd2, 11, "pre_reset");
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (busy && !cnt_up_down && !cnt_load && cnt_count == 4'd5) found = 1;
    end
    chk("reset_reach_down", found, 1);
    rst = 1'b0;
    #1;
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_load", int'(cnt_load), 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_count_held", int'(cnt_count), 5);
    issue(4'd3, 4'd2, 4'd5, 4'd1, 1'b0, 1'b0, 4'd2, 8, "post_reset");
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
